// File: rtl/projectile_ctl_if.sv
// Bundle between the weapon-positioning stage, the archer projectile controller
// and its consumers (sprite renderer, boss damage logic).
interface projectile_ctl_if;
  logic        frame_tick;
  logic        fire;
  logic        archer_active;
  logic        flip_hor;
  logic [11:0] spawn_x;
  logic [11:0] spawn_y;
  logic [11:0] target_x;
  logic [11:0] target_y;
  logic        target_alive;
  logic        proj_active;
  logic [11:0] proj_x;
  logic [11:0] proj_y;
  logic        proj_flip;
  logic        hit;
  logic        ready;

  modport master (
    output frame_tick, fire, archer_active, flip_hor,
    output spawn_x, spawn_y, target_x, target_y, target_alive,
    input  proj_active, proj_x, proj_y, proj_flip, hit, ready
  );

  modport slave (
    input  frame_tick, fire, archer_active, flip_hor,
    input  spawn_x, spawn_y, target_x, target_y, target_alive,
    output proj_active, proj_x, proj_y, proj_flip, hit, ready
  );
endinterface

// File: rtl/projectile_ctl.sv
// Archer projectile controller: launches one arrow per fire edge, advances it
// once per frame, ends the flight on hit / screen edge / range, then cools down.
module projectile_ctl #(
  parameter int SPEED           = 8,
  parameter int SCREEN_W        = 1024,
  parameter int MAX_RANGE       = 600,
  parameter int HIT_HALF_W      = 16,
  parameter int HIT_HALF_H      = 16,
  parameter int COOLDOWN_FRAMES = 20
) (
  input  logic              clk,
  input  logic              rst,
  projectile_ctl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  localparam logic [11:0] SPEED_12  = 12'(SPEED);
  localparam logic [12:0] SPEED_13  = 13'(SPEED);
  localparam logic [12:0] SCREEN_13 = 13'(SCREEN_W);
  localparam logic [11:0] RANGE_12  = 12'(MAX_RANGE);
  localparam logic [11:0] HALF_W_12 = 12'(HIT_HALF_W);
  localparam logic [11:0] HALF_H_12 = 12'(HIT_HALF_H);
  localparam logic [11:0] COOL_12   = 12'(COOLDOWN_FRAMES);

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        fire_q, fire_d;
  logic [11:0] proj_x_q, proj_x_d;
  logic [11:0] proj_y_q, proj_y_d;
  logic        proj_flip_q, proj_flip_d;
  logic [11:0] dist_q, dist_d;
  logic [11:0] cool_q, cool_d;
  logic        hit_q, hit_d;
  logic        proj_active_q, proj_active_d;
  logic        ready_q, ready_d;

  logic        fire_rise;
  logic        hit_cond;
  logic        edge_cond;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    fire_d      = bus.fire;
    proj_x_d    = proj_x_q;
    proj_y_d    = proj_y_q;
    proj_flip_d = proj_flip_q;
    dist_d      = dist_q;
    cool_d      = cool_q;
    hit_d       = 1'b0;

    fire_rise = bus.fire & ~fire_q;
    hit_cond  = bus.target_alive
              && (abs_diff(proj_x_q, bus.target_x) < HALF_W_12)
              && (abs_diff(proj_y_q, bus.target_y) < HALF_H_12);
    // Widened so neither end of the screen can wrap the comparison.
    if (proj_flip_q) begin
      edge_cond = ({1'b0, proj_x_q} < SPEED_13);
    end else begin
      edge_cond = (({1'b0, proj_x_q} + SPEED_13) >= SCREEN_13);
    end

    case (state_q)
      IDLE: begin
        if (fire_rise && bus.archer_active) begin
          proj_x_d    = bus.spawn_x;
          proj_y_d    = bus.spawn_y;
          proj_flip_d = bus.flip_hor;
          dist_d      = 12'd0;
          state_d     = FLY;
        end else begin
          state_d = IDLE;
        end
      end
      FLY: begin
        if (bus.frame_tick) begin
          if (hit_cond) begin
            hit_d   = 1'b1;
            cool_d  = 12'd0;
            state_d = COOLDOWN;
          end else if (edge_cond || (dist_q >= RANGE_12)) begin
            cool_d  = 12'd0;
            state_d = COOLDOWN;
          end else begin
            if (proj_flip_q) begin
              proj_x_d = proj_x_q - SPEED_12;
            end else begin
              proj_x_d = proj_x_q + SPEED_12;
            end
            dist_d = dist_q + SPEED_12;
          end
        end else begin
          state_d = FLY;
        end
      end
      COOLDOWN: begin
        if (bus.frame_tick) begin
          if ((cool_q + 12'd1) >= COOL_12) begin
            cool_d  = 12'd0;
            state_d = IDLE;
          end else begin
            cool_d = cool_q + 12'd1;
          end
        end else begin
          state_d = COOLDOWN;
        end
      end
      default: begin
        cool_d  = 12'd0;
        state_d = IDLE;
      end
    endcase

    proj_active_d = (state_d == FLY);
    ready_d       = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fire_q        <= 1'b0;
      proj_x_q      <= 12'd0;
      proj_y_q      <= 12'd0;
      proj_flip_q   <= 1'b0;
      dist_q        <= 12'd0;
      cool_q        <= 12'd0;
      hit_q         <= 1'b0;
      proj_active_q <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      fire_q        <= fire_d;
      proj_x_q      <= proj_x_d;
      proj_y_q      <= proj_y_d;
      proj_flip_q   <= proj_flip_d;
      dist_q        <= dist_d;
      cool_q        <= cool_d;
      hit_q         <= hit_d;
      proj_active_q <= proj_active_d;
      ready_q       <= ready_d;
    end
  end

  assign bus.proj_active = proj_active_q;
  assign bus.proj_x      = proj_x_q;
  assign bus.proj_y      = proj_y_q;
  assign bus.proj_flip   = proj_flip_q;
  assign bus.hit         = hit_q;
  assign bus.ready       = ready_q;

endmodule

// File: tb/tb_projectile_ctl.sv
// Self-checking bench for projectile_ctl: directed scenarios plus randomized
// flights checked against a per-tick integer flight model.
module tb_projectile_ctl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  projectile_ctl_if pif ();
  projectile_ctl dut (.clk(clk), .rst(rst), .bus(pif));

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic launch(input int sx, input int sy, input int fl);
    pif.spawn_x       = 12'(sx);
    pif.spawn_y       = 12'(sy);
    pif.flip_hor      = fl[0];
    pif.archer_active = 1'b1;
    pif.fire          = 1'b0;
    @(negedge clk);
    pif.fire = 1'b1;
    @(negedge clk);
    pif.fire = 1'b0;
  endtask

  task automatic tick();
    pif.frame_tick = 1'b1;
    @(negedge clk);
    pif.frame_tick = 1'b0;
  endtask

  // Launch, then tick until the model says the flight ends, checking each frame.
  task automatic fly(input string name, input int sx, input int sy, input int fl,
                     input int tx, input int ty, input int alive);
    int x, d, n;
    bit done, exp_hit;
    pif.target_x     = 12'(tx);
    pif.target_y     = 12'(ty);
    pif.target_alive = alive[0];
    launch(sx, sy, fl);
    checks++;
    if (pif.proj_active !== 1'b1 || pif.proj_x !== 12'(sx) || pif.proj_y !== 12'(sy)
        || pif.proj_flip !== fl[0] || pif.ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_launch: active=%0b x=%0d y=%0d flip=%0b ready=%0b, want 1 %0d %0d %0b 0",
               name, pif.proj_active, pif.proj_x, pif.proj_y, pif.proj_flip, pif.ready,
               sx, sy, fl[0]);
    end
    x = sx; d = 0; done = 1'b0; n = 0;
    while (!done && n < 200) begin
      pif.spawn_x       = 12'($urandom);
      pif.spawn_y       = 12'($urandom);
      pif.flip_hor      = 1'($urandom);
      pif.archer_active = 1'($urandom);
      pif.fire          = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_hit = (alive != 0) && (iabs(x - tx) < 16) && (iabs(sy - ty) < 16);
      done    = exp_hit || (fl != 0 ? (x < 8) : (x + 8 >= 1024)) || (d >= 600);
      if (!done) begin
        x = (fl != 0) ? x - 8 : x + 8;
        d = d + 8;
      end
      tick();
      n++;
      checks++;
      if (pif.proj_active !== !done || pif.proj_x !== 12'(x) || pif.hit !== exp_hit
          || pif.proj_y !== 12'(sy)) begin
        failures++;
        $display("FAIL %s_tick%0d: active=%0b x=%0d y=%0d hit=%0b, want %0b %0d %0d %0b",
                 name, n, pif.proj_active, pif.proj_x, pif.proj_y, pif.hit,
                 !done, x, sy, exp_hit);
      end
    end
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: flight did not end within 200 ticks", name);
    end
    @(negedge clk);
    checks++;
    if (pif.hit !== 1'b0 || pif.proj_x !== 12'(x) || pif.proj_active !== 1'b0) begin
      failures++;
      $display("FAIL %s_after: hit=%0b x=%0d active=%0b, want 0 %0d 0",
               name, pif.hit, pif.proj_x, pif.proj_active, x);
    end
    pif.fire = 1'b0;
  endtask

  // Twenty cooldown frames with fire activity; the expiring tick carries a fire edge.
  task automatic cooldown(input string name);
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) begin
        pif.fire = 1'b0;
        @(negedge clk);
        pif.fire = 1'b1;
      end else begin
        pif.fire = k[0];
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      tick();
      checks++;
      if (pif.ready !== (k == 20) || pif.proj_active !== 1'b0) begin
        failures++;
        $display("FAIL %s_cool%0d: ready=%0b active=%0b, want %0b 0",
                 name, k, pif.ready, pif.proj_active, (k == 20));
      end
    end
    @(negedge clk);
    checks++;
    if (pif.ready !== 1'b1 || pif.proj_active !== 1'b0) begin
      failures++;
      $display("FAIL %s_drop: ready=%0b active=%0b, want 1 0", name, pif.ready, pif.proj_active);
    end
    pif.fire = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pif.proj_active !== 1'b0 || pif.proj_x !== 12'd0 || pif.proj_y !== 12'd0
        || pif.proj_flip !== 1'b0 || pif.hit !== 1'b0 || pif.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: active=%0b x=%0d y=%0d flip=%0b hit=%0b ready=%0b, want 0 0 0 0 0 1",
               pif.proj_active, pif.proj_x, pif.proj_y, pif.proj_flip, pif.hit, pif.ready);
    end
  endtask

  task automatic test_directed();
    fly("hit", 500, 300, 0, 560, 300, 1);
    checks++;
    if (pif.proj_x !== 12'd548) begin
      failures++;
      $display("FAIL hit_final_x: got %0d want 548", pif.proj_x);
    end
    cooldown("hit");
    fly("right_edge", 1000, 50, 0, 0, 0, 0);
    checks++;
    if (pif.proj_x !== 12'd1016) begin
      failures++;
      $display("FAIL right_edge_x: got %0d want 1016", pif.proj_x);
    end
    cooldown("right_edge");
    fly("left_edge", 10, 70, 1, 0, 0, 0);
    checks++;
    if (pif.proj_x !== 12'd2) begin
      failures++;
      $display("FAIL left_edge_x: got %0d want 2", pif.proj_x);
    end
    cooldown("left_edge");
    fly("range", 100, 200, 0, 0, 0, 0);
    checks++;
    if (pif.proj_x !== 12'd700) begin
      failures++;
      $display("FAIL range_x: got %0d want 700", pif.proj_x);
    end
    cooldown("range");
  endtask

  task automatic test_gating();
    pif.archer_active = 1'b0;
    pif.fire = 1'b0;
    @(negedge clk);
    pif.fire = 1'b1;
    @(negedge clk);
    pif.fire = 1'b0;
    checks++;
    if (pif.ready !== 1'b1 || pif.proj_active !== 1'b0) begin
      failures++;
      $display("FAIL gating: ready=%0b active=%0b, want 1 0", pif.ready, pif.proj_active);
    end
  endtask

  task automatic test_launch_tick_and_reset();
    pif.target_alive  = 1'b0;
    pif.spawn_x       = 12'd500;
    pif.spawn_y       = 12'd100;
    pif.flip_hor      = 1'b0;
    pif.archer_active = 1'b1;
    @(negedge clk);
    pif.fire = 1'b1;
    tick();
    pif.fire = 1'b0;
    checks++;
    if (pif.proj_active !== 1'b1 || pif.proj_x !== 12'd500) begin
      failures++;
      $display("FAIL launch_tick: active=%0b x=%0d, want 1 500", pif.proj_active, pif.proj_x);
    end
    repeat (4) tick();
    checks++;
    if (pif.proj_x !== 12'd532) begin
      failures++;
      $display("FAIL pre_reset_x: got %0d want 532", pif.proj_x);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pif.proj_active !== 1'b0 || pif.proj_x !== 12'd0 || pif.hit !== 1'b0 || pif.ready !== 1'b1) begin
      failures++;
      $display("FAIL midflight_reset: active=%0b x=%0d hit=%0b ready=%0b, want 0 0 0 1",
               pif.proj_active, pif.proj_x, pif.hit, pif.ready);
    end
  endtask

  task automatic test_random();
    int sx, sy, fl, tx, ty, al;
    for (int i = 0; i < 12; i++) begin
      sx = $urandom_range(0, 1023);
      sy = $urandom_range(20, 1000);
      fl = $urandom_range(0, 1);
      al = ($urandom_range(0, 3) != 0) ? 1 : 0;
      tx = (fl != 0) ? sx - $urandom_range(0, 300) : sx + $urandom_range(0, 300);
      if (tx < 0) tx = 0;
      if (tx > 4095) tx = 4095;
      ty = sy + $urandom_range(0, 40) - 20;
      fly("random", sx, sy, fl, tx, ty, al);
      cooldown("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    pif.frame_tick    = 1'b0;
    pif.fire          = 1'b0;
    pif.archer_active = 1'b0;
    pif.flip_hor      = 1'b0;
    pif.spawn_x       = 12'd0;
    pif.spawn_y       = 12'd0;
    pif.target_x      = 12'd0;
    pif.target_y      = 12'd0;
    pif.target_alive  = 1'b0;
    test_reset();
    test_directed();
    test_gating();
    test_launch_tick_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/projectile_ctl.md
# projectile_ctl

Archer projectile controller. It consumes the spawn point and facing produced by the weapon-positioning stage, launches one arrow per fire edge, and advances it once per frame. It terminates the flight on target hit, screen edge or maximum range, then enforces a cooldown. It sits between the weapon-offset logic and the projectile sprite renderer / boss damage logic.

## Interface
Parameters:
- SPEED, 8, pixels moved per frame tick
- SCREEN_W, 1024, horizontal screen size in pixels
- MAX_RANGE, 600, travelled distance in pixels that ends a flight
- HIT_HALF_W, 16, horizontal hit half-window
- HIT_HALF_H, 16, vertical hit half-window
- COOLDOWN_FRAMES, 20, frame ticks spent in COOLDOWN

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- fire  in  1  mouse click level; a rising edge is a shot request
- archer_active  in  1  archer class selected; shots are gated by this
- flip_hor  in  1  facing: 0 = right, 1 = left
- spawn_x, spawn_y  in  12 each  projectile spawn point (weapon projectile offset)
- target_x, target_y  in  12 each  target centre
- target_alive  in  1  enables hit detection
- proj_active  out  1  projectile in flight (drives sprite enable)
- proj_x, proj_y  out  12 each  current projectile position
- proj_flip  out  1  facing latched at launch
- hit  out  1  one-cycle pulse on target hit
- ready  out  1  high only in IDLE

## Operation
- Reset values: state IDLE, proj_active 0, proj_x 0, proj_y 0, proj_flip 0, hit 0, ready 1, distance and cooldown counters 0, fire edge register 0.
- Fire edge detection: fire_q is registered every cycle. fire_rise = fire & ~fire_q.
- IDLE:
  - On fire_rise with archer_active=1: latch spawn_x, spawn_y and flip_hor into proj_x, proj_y and proj_flip, clear dist, go to FLY.
  - fire_rise with archer_active=0 is dropped.
- FLY: action happens on frame_tick only. Conditions are evaluated on the current latched position, in priority order:
  1. Hit: target_alive and |proj_x-target_x| < HIT_HALF_W and |proj_y-target_y| < HIT_HALF_H. Pulse hit and go to COOLDOWN.
  2. Edge: if proj_flip=0 and proj_x+SPEED >= SCREEN_W, or proj_flip=1 and proj_x < SPEED. Go to COOLDOWN with no hit.
  3. Range: dist >= MAX_RANGE. Go to COOLDOWN with no hit.
  4. Otherwise move: proj_x ± SPEED, and dist += SPEED. proj_y is unchanged.
- COOLDOWN: counter increments on each frame_tick. When it reaches COOLDOWN_FRAMES, clear it and go to IDLE.
- Fire edges in FLY or COOLDOWN are discarded, not queued.
- Changes to archer_active, flip_hor or spawn inputs mid-flight have no effect on the current flight.
- proj_active = (state == FLY). ready = (state == IDLE).
- Arithmetic:
  - All positions are 12-bit unsigned. Absolute differences are computed by comparing the operands and subtracting the smaller, with no signed wrap.
  - Edge checks prevent proj_x underflow or overflow.
  - dist is 12 bits.

## Timing
- Fire to launch: fire_rise in cycle N. state=FLY, proj_active=1 and position latched are visible at cycle N+1.
- Tick to move: frame_tick in cycle N. New proj_x is visible at cycle N+1.
- hit: high exactly one cycle, at N+1 after the terminating tick. proj_active falls in that same cycle.
- proj_x and proj_y hold their last value after termination until the next launch.
- A frame_tick coinciding with the launch cycle (IDLE) does not move the projectile.
- frame_tick and fire_rise in the same COOLDOWN cycle that expires: go to IDLE and drop the fire.
- Reset mid-flight: all outputs return to reset values on the next edge, and no hit pulse is generated.

## Test plan
- Hit: spawn (500,300), flip 0, target (560,300) alive, fire edge. After ticks 1-6, proj_x reads 508…548. Tick 7 → hit=1 for one cycle, proj_active=0, proj_x=548.
- Right edge: spawn_x=1000, flip 0, target dead. Tick 1 → 1008, tick 2 → 1016, tick 3 → proj_active=0, hit stays 0.
- Left edge: spawn_x=10, flip 1. Tick 1 → proj_x=2, tick 2 → flight ends, no underflow, proj_x=2.
- Range: spawn_x=100, flip 0, target dead. 75 ticks reach proj_x=700. Tick 76 → proj_active=0.
- Cooldown and gating:
  - Fire during flight and during cooldown ticks 1-19 → no relaunch.
  - After 20 ticks ready=1, and a new fire edge launches.
  - With archer_active=0, a fire edge keeps ready=1.
- Reset: assert rst during flight at proj_x=532 → next cycle proj_active=0, proj_x=0, hit=0, ready=1.
